io_tx_buffer: RTL
=================

# io_tx_buffer

Output-side I/O buffer between the CPU's external memory bus and the UART transmitter. It snoops CPU writes to the I/O window and captures bytes written to 0x30000 into a small FIFO. It drains them to the UART whenever the UART is not full, and tells the CPU to hold off when the FIFO is nearly full. It turns the program-stop write (0x30004) into a single halt pulse that is issued only after every queued byte has been sent.

## Interface
Parameters:
- DEPTH_LOG2, default 3; FIFO depth = 2^DEPTH_LOG2 entries (8).

Ports:
- clk_in  input  1  system clock; all state changes on its rising edge.
- rst_in  input  1  reset, synchronous, active-low; one clock, synchronous active-low reset.
- rdy_in  input  1  global ready; when low, all state is frozen.
- cpu_a  input  32  CPU bus address; only [17:16] and [2] are decoded.
- cpu_dout  input  8  CPU write data.
- cpu_wr  input  1  CPU write strobe (1 = write).
- buf_full_out  output  1  to CPU: do not issue further TX writes (registered).
- uart_data_out  output  8  byte to UART (registered).
- uart_wr_out  output  1  UART write strobe, one cycle per byte (registered).
- uart_full_in  input  1  UART TX buffer full.
- halt_out  output  1  one-cycle pulse: program stop, all output drained.
- overflow_out  output  1  sticky: a TX byte was dropped because the FIFO was full.

## Operation
- Decode:
  - TX write: cpu_wr=1, cpu_a[17:16]=2'b11 and cpu_a[2]=0.
  - Stop write: cpu_wr=1, cpu_a[17:16]=2'b11 and cpu_a[2]=1.
  - All other bus traffic is ignored.
- TX writes with cpu_dout=8'h00 are ignored and do not affect the FIFO.
- FIFO storage and pointers:
  - Circular buffer with head and tail pointers of DEPTH_LOG2 bits, wrapping modulo depth.
  - Occupancy count is DEPTH_LOG2+1 bits.
- Push: a valid TX write in RUN state pushes cpu_dout at tail.
  - If the count equals the depth and no pop happens in the same cycle, the byte is dropped and overflow_out is set.
  - overflow_out clears only on reset.
- Pop condition: FIFO non-empty, uart_full_in=0 and rdy_in=1.
  - On a pop, the head byte goes to uart_data_out, uart_wr_out is 1 for the next cycle, and head advances.
  - Otherwise uart_wr_out is 0 and uart_data_out holds its last value.
- Push and pop in the same cycle: allowed at any occupancy, including full. The count is unchanged.
- buf_full_out is registered and equals 1 when the next-state count is ≥ depth−1. One write issued in the same cycle that buf_full_out rises is still absorbed.
- Stop state machine:
  - RUN: a stop write moves to DRAIN. A TX write in that same cycle is still pushed.
  - DRAIN: TX and stop writes are ignored. The FIFO keeps popping. When the count is 0 and no pop is in flight, halt_out pulses for one cycle and the state moves to STOPPED.
  - STOPPED: all writes are ignored and halt_out stays 0. Only reset leaves this state.
- rdy_in=0: no push, no pop, no state transition. uart_wr_out and halt_out are 0 that cycle. All bus inputs are ignored.

## Timing
- Reset (rst_in=0 at an edge) sets:
  - count=0, head=0, tail=0, state=RUN;
  - uart_wr_out=0, uart_data_out=8'h00, buf_full_out=0, halt_out=0, overflow_out=0.
- Reset mid-operation discards all queued bytes. No partial strobe is produced.
- Latency without bypass: a TX write sampled at edge E is pushed at E. It is popped at E+1 at the earliest, so uart_wr_out is high during the cycle after E+1.
- Sustained drain throughput: one byte per cycle while uart_full_in=0.
- uart_full_in is sampled at the pop edge. A UART that goes full while uart_wr_out is high must still accept that byte.
- halt_out rises no earlier than the cycle after the last uart_wr_out pulse.

## Configuration
- IO_TX_BYPASS_EN defined:
  - A TX write sampled at edge E when the FIFO is empty, uart_full_in=0 and state=RUN skips storage.
  - uart_wr_out is high during the cycle after E, with uart_data_out=cpu_dout. The count is unchanged.
- IO_TX_BYPASS_EN undefined: every byte passes through FIFO storage with the latency given under Timing.
- Ordering, overflow and halt behaviour are identical in both builds.

## Test plan
- Reset, then TX writes 8'h41, 8'h42, 8'h43 on consecutive cycles with uart_full_in=0 -> three uart_wr_out pulses with data 41, 42, 43 in order, starting at E+1 (E with bypass).
- Hold uart_full_in=1 and write 7 bytes -> buf_full_out rises after the 7th. A 9th write sets overflow_out. Release uart_full_in -> exactly 8 bytes emitted in order, the dropped byte never appears.
- TX write of 8'h00, then a write to 0x20000 -> no push and no uart_wr_out.
- Queue 3 bytes with uart_full_in=1, stop write, then a TX write of 8'h55 -> 8'h55 ignored. On release, 3 pulses, then halt_out for exactly one cycle. A later stop write gives no second pulse.
- With 4 bytes queued and draining, hold rdy_in=0 for 5 cycles -> no uart_wr_out and the count is frozen. Resume -> the remaining bytes come out with none lost or duplicated.
- Drive rst_in=0 during DRAIN with 2 bytes queued -> all outputs at their reset values next cycle. Subsequent writes are accepted normally in RUN.

Source files
------------

// File: rtl/io_tx_buffer.sv
// io_tx_buffer: snoops CPU writes to the I/O window, queues TX bytes written
// to 0x30000 in a small circular FIFO, drains them to the UART, and converts
// the program-stop write (0x30004) into a single halt pulse once the FIFO and
// the UART strobe are both idle.
// Optional feature macro: IO_TX_BYPASS_EN -- when defined, a TX write that
// finds the FIFO empty and the UART ready goes straight to the UART outputs.
module io_tx_buffer #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic        buf_full_out,
  output logic [7:0]  uart_data_out,
  output logic        uart_wr_out,
  input  logic        uart_full_in,
  output logic        halt_out,
  output logic        overflow_out
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Count values for "completely full" and "one slot left".
  localparam logic [DEPTH_LOG2:0] FULL_CNT   = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ALMOST_CNT = {1'b0, {DEPTH_LOG2{1'b1}}};

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_STOPPED
  } state_t;

  state_t                state_reg;
  logic [DEPTH_LOG2-1:0] head_reg;
  logic [DEPTH_LOG2-1:0] tail_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [DEPTH_LOG2:0]   count_next;
  logic [7:0]            mem [DEPTH];

  logic io_sel;
  logic tx_wr;
  logic stop_wr;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic bypass;
  logic drop;
  logic halt_now;

  // Only address bits [17:16] and [2] take part in the decode.
  logic unused_addr;
  assign unused_addr = ^{cpu_a[31:18], cpu_a[15:3], cpu_a[1:0]};

  // Bus decode and FIFO control; everything is qualified by rdy_in so a
  // frozen cycle produces no push, pop or state change.
  always_comb begin
    io_sel     = rdy_in && cpu_wr && (cpu_a[17:16] == 2'b11);
    tx_wr      = io_sel && !cpu_a[2] && (cpu_dout != 8'h00) && (state_reg == ST_RUN);
    stop_wr    = io_sel && cpu_a[2] && (state_reg == ST_RUN);
    fifo_empty = (count_reg == '0);
    fifo_full  = (count_reg == FULL_CNT);
    pop        = !fifo_empty && !uart_full_in && rdy_in;
`ifdef IO_TX_BYPASS_EN
    bypass     = tx_wr && fifo_empty && !uart_full_in;
`else
    bypass     = 1'b0;
`endif
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    push       = tx_wr && !bypass && (!fifo_full || pop);
    drop       = tx_wr && !bypass && fifo_full && !pop;
    // Halt waits for an empty FIFO and for the last strobe to have finished.
    halt_now   = rdy_in && (state_reg == ST_DRAIN) && fifo_empty && !uart_wr_out;
    count_next = count_reg + {{DEPTH_LOG2{1'b0}}, push} - {{DEPTH_LOG2{1'b0}}, pop};
  end

  // Pointers, count, UART outputs, sticky overflow and the stop state machine.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg     <= ST_RUN;
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      buf_full_out  <= 1'b0;
      uart_data_out <= 8'h00;
      uart_wr_out   <= 1'b0;
      halt_out      <= 1'b0;
      overflow_out  <= 1'b0;
    end else begin
      uart_wr_out  <= 1'b0;
      halt_out     <= 1'b0;
      count_reg    <= count_next;
      buf_full_out <= (count_next >= ALMOST_CNT);
      if (pop) begin
        uart_data_out <= mem[head_reg];
        uart_wr_out   <= 1'b1;
        head_reg      <= head_reg + 1'b1;
      end else if (bypass) begin
        uart_data_out <= cpu_dout;
        uart_wr_out   <= 1'b1;
      end
      if (push) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (drop) begin
        overflow_out <= 1'b1;
      end
      case (state_reg)
        ST_RUN: begin
          if (stop_wr) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (halt_now) begin
            halt_out  <= 1'b1;
            state_reg <= ST_STOPPED;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // FIFO storage: write-only port here, read is registered into uart_data_out.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[tail_reg] <= cpu_dout;
    end
  end

endmodule
